// File: rtl/and4_resp_checker_if.sv
`default_nettype none
// ============================================================================
//  Module      : and4_resp_checker_if
//  Description : Stimulus/response handshake bundle feeding the AND4 checker.
//  Revision    : 1.0  initial release
// ============================================================================
interface and4_resp_checker_if;
   logic       in_valid;
   logic [3:0] in_vec;
   logic       in_f;
   logic       in_ready;

   modport master (
      output in_valid,
      output in_vec,
      output in_f,
      input  in_ready
   );

   modport slave (
      input  in_valid,
      input  in_vec,
      input  in_f,
      output in_ready
   );
endinterface
`default_nettype wire

// File: rtl/and4_resp_checker.sv
`default_nettype none
// ============================================================================
//  Module      : and4_resp_checker
//  Description : Scores observed 4-input AND responses over a fixed-length run,
//                tracking pass/fail counts, first failing vector and coverage.
//  Revision    : 1.0  initial release
// ============================================================================
module and4_resp_checker #(
   parameter int NUM_VEC = 16,
   parameter int CNT_W   = 5
) (
   input  wire logic             clk,
   input  wire logic             rst_n,
   input  wire logic             start,
   and4_resp_checker_if.slave    rsp,
   output logic                  busy,
   output logic                  done,
   output logic                  pass,
   output logic [CNT_W-1:0]      pass_cnt,
   output logic [CNT_W-1:0]      fail_cnt,
   output logic [3:0]            first_fail_vec,
   output logic                  first_fail_vld,
   output logic [15:0]           cov_mask,
   output logic                  full_cov
);

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_RUN  = 2'd1,
      S_DONE = 2'd2
   } state_t;

   localparam logic [CNT_W:0] c_num_vec = (CNT_W+1)'(NUM_VEC);

   state_t           r_state;
   logic             r_in_ready;
   logic             r_busy;
   logic             r_done;
   logic             r_pass;
   logic [CNT_W-1:0] r_pass_cnt;
   logic [CNT_W-1:0] r_fail_cnt;
   logic [3:0]       r_ff_vec;
   logic             r_ff_vld;
   logic [15:0]      r_cov_mask;

   logic             w_accept;
   logic             w_match;
   logic [CNT_W-1:0] w_pass_cnt_nxt;
   logic [CNT_W-1:0] w_fail_cnt_nxt;
   logic [CNT_W:0]   w_total_nxt;
   logic             w_last;
   logic [15:0]      w_vec_bit;

   // r_in_ready is only ever high in RUN, so it alone qualifies the handshake
   assign w_accept       = r_in_ready & rsp.in_valid;
   assign w_match        = (rsp.in_f == (&rsp.in_vec));
   assign w_pass_cnt_nxt = r_pass_cnt + CNT_W'(w_accept &  w_match);
   assign w_fail_cnt_nxt = r_fail_cnt + CNT_W'(w_accept & ~w_match);
   assign w_total_nxt    = {1'b0, w_pass_cnt_nxt} + {1'b0, w_fail_cnt_nxt};
   assign w_last         = w_accept & (w_total_nxt == c_num_vec);
   assign w_vec_bit      = 16'(1) << rsp.in_vec;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state    <= S_IDLE;
         r_in_ready <= 1'b0;
         r_busy     <= 1'b0;
         r_done     <= 1'b0;
         r_pass     <= 1'b0;
         r_pass_cnt <= '0;
         r_fail_cnt <= '0;
         r_ff_vec   <= 4'h0;
         r_ff_vld   <= 1'b0;
         r_cov_mask <= 16'h0000;
      end else begin
         case (r_state)
            S_IDLE, S_DONE: begin
               // Results from a finished run hold until the next start
               if (start) begin
                  r_state    <= S_RUN;
                  r_in_ready <= 1'b1;
                  r_busy     <= 1'b1;
                  r_done     <= 1'b0;
                  r_pass     <= 1'b0;
                  r_pass_cnt <= '0;
                  r_fail_cnt <= '0;
                  r_ff_vec   <= 4'h0;
                  r_ff_vld   <= 1'b0;
                  r_cov_mask <= 16'h0000;
               end
            end

            S_RUN: begin
               if (w_accept) begin
                  r_pass_cnt <= w_pass_cnt_nxt;
                  r_fail_cnt <= w_fail_cnt_nxt;
                  r_cov_mask <= r_cov_mask | w_vec_bit;
                  if (!w_match && !r_ff_vld) begin
                     r_ff_vec <= rsp.in_vec;
                     r_ff_vld <= 1'b1;
                  end
                  if (w_last) begin
                     r_state    <= S_DONE;
                     r_in_ready <= 1'b0;
                     r_busy     <= 1'b0;
                     r_done     <= 1'b1;
                     r_pass     <= (w_fail_cnt_nxt == '0);
                  end
               end
            end

            default: begin
               r_state    <= S_IDLE;
               r_in_ready <= 1'b0;
               r_busy     <= 1'b0;
               r_done     <= 1'b0;
               r_pass     <= 1'b0;
            end
         endcase
      end
   end

   assign rsp.in_ready   = r_in_ready;
   assign busy           = r_busy;
   assign done           = r_done;
   assign pass           = r_pass;
   assign pass_cnt       = r_pass_cnt;
   assign fail_cnt       = r_fail_cnt;
   assign first_fail_vec = r_ff_vec;
   assign first_fail_vld = r_ff_vld;
   assign cov_mask       = r_cov_mask;
   assign full_cov       = &r_cov_mask;

endmodule
`default_nettype wire
